bit_unstuffer: RTL and testbench

Receive-side counterpart of the transmitter's bit stuffer. It sits after the NRZI decoder and before the receive shift register. It counts consecutive 1 bits, deletes the stuffed 0 that follows every run of MAX_ONES ones, and flags a bit-stuff violation when that position holds a 1. Output bits are forwarded as single-cycle valid strobes, one per retained bit.

---
 rtl/bit_unstuffer.sv | 75 +++++++
 tb/tb_bit_unstuffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_unstuffer.sv
// Receive-side bit unstuffer: removes the stuffed 0 after every MAX_ONES run of 1s
// and flags a sticky stuff error when that slot carries a 1 instead.
module bit_unstuffer #(
    parameter int MAX_ONES = 6,
    localparam int CNT_W   = $clog2(MAX_ONES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear,
    output logic             data_valid,
    output logic             data_out,
    output logic             stripped,
    output logic             stuff_err,
    output logic [CNT_W-1:0] ones_cnt
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] EXPECT0 = 2'd1;
    localparam logic [1:0] ERR     = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ONES);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt_inc;

    // Only used in RUN, where ones_cnt < MAX_ONES, so this cannot wrap.
    assign cnt_inc = ones_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= RUN;
            data_valid <= 1'b0;
            data_out   <= 1'b0;
            stripped   <= 1'b0;
            stuff_err  <= 1'b0;
            ones_cnt   <= '0;
        end else begin
            data_valid <= 1'b0;
            stripped   <= 1'b0;
            // clear wins over a coincident bit_valid; that bit is discarded.
            if (clear) begin
                state     <= RUN;
                stuff_err <= 1'b0;
                ones_cnt  <= '0;
            end else if (bit_valid) begin
                case (state)
                    RUN: begin
                        data_valid <= 1'b1;
                        data_out   <= bit_in;
                        if (bit_in) begin
                            ones_cnt <= cnt_inc;
                            if (cnt_inc == CNT_MAX) state <= EXPECT0;
                        end else begin
                            ones_cnt <= '0;
                        end
                    end
                    EXPECT0: begin
                        if (!bit_in) begin
                            stripped <= 1'b1;
                            ones_cnt <= '0;
                            state    <= RUN;
                        end else begin
                            stuff_err <= 1'b1;
                            state     <= ERR;
                        end
                    end
                    default: ;  // ERR: bits are dropped until clear
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bit_unstuffer.sv
// Scoreboard bench for bit_unstuffer: stimulus pushes expected outputs (kind, value,
// arrival cycle); a negedge monitor pops and compares every data_valid / stripped pulse.
module tb_bit_unstuffer;

    localparam int MAX_ONES = 6;
    localparam int CNT_W    = $clog2(MAX_ONES + 1);

    localparam int K_NONE = 0;
    localparam int K_DATA = 1;
    localparam int K_STRIP = 2;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             clear = 1'b0;
    logic             data_valid;
    logic             data_out;
    logic             stripped;
    logic             stuff_err;
    logic [CNT_W-1:0] ones_cnt;

    bit_unstuffer #(.MAX_ONES(MAX_ONES)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .clear      (clear),
        .data_valid (data_valid),
        .data_out   (data_out),
        .stripped   (stripped),
        .stuff_err  (stuff_err),
        .ones_cnt   (ones_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   kind;
        logic val;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   dv_cnt = 0;
    int   strip_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs change at posedge+1, so a strobe driven in negedge-count c
    // is captured at the next posedge and its response is sampled at count c+2.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        cyc++;
        if (n_rst && (data_valid || stripped)) begin
            kind = (data_valid && stripped) ? 3 : (data_valid ? K_DATA : K_STRIP);
            if (data_valid) dv_cnt++;
            if (stripped) strip_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_output", kind, K_NONE);
            end else begin
                e = q.pop_front();
                chk("out_kind", kind, e.kind);
                chk("out_cycle", cyc, e.cyc);
                if (e.kind == K_DATA) chk("data_out", int'(data_out), int'(e.val));
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic c, input int e);
        exp_t t;
        @(posedge clk);
        #1;
        bit_valid = v;
        bit_in    = b;
        clear     = c;
        if (e != K_NONE) begin
            t.kind = e;
            t.val  = b;
            t.cyc  = cyc + 2;
            q.push_back(t);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, K_NONE);
    endtask

    task automatic do_clear();
        drive(1'b0, 1'b0, 1'b1, K_NONE);
        idle(1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_data_valid"}, int'(data_valid), 0);
        chk({name, "_data_out"}, int'(data_out), 0);
        chk({name, "_stripped"}, int'(stripped), 0);
        chk({name, "_stuff_err"}, int'(stuff_err), 0);
        chk({name, "_ones_cnt"}, int'(ones_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset, including a reset asserted mid-clock while strobes are active
        #1;
        chk_zero("rst_init");
        idle(1);
        n_rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, K_DATA);
        drive(1'b1, 1'b1, 1'b0, K_DATA);
        #3;
        n_rst = 1'b0;
        #1;
        chk_zero("rst_async");
        q.delete();
        drive(1'b1, 1'b1, 1'b0, K_NONE);
        chk_zero("rst_hold1");
        drive(1'b0, 1'b0, 1'b0, K_NONE);
        drive(1'b1, 1'b1, 1'b0, K_NONE);
        chk_zero("rst_hold2");
        drive(1'b0, 1'b0, 1'b0, K_NONE);
        n_rst = 1'b1;
        idle(2);
        chk_zero("rst_release");

        // 2. Stuffed zero removal: 1x6, 0 (stripped), 1
        repeat (6) drive(1'b1, 1'b1, 1'b0, K_DATA);
        drive(1'b1, 1'b0, 1'b0, K_STRIP);
        drive(1'b1, 1'b1, 1'b0, K_DATA);
        idle(1);
        chk("t2_ones_cnt", int'(ones_cnt), 1);
        chk("t2_stuff_err", int'(stuff_err), 0);
        do_clear();
        chk("clr_ones_cnt", int'(ones_cnt), 0);

        // 3. Short run 1,1,1,1,1,0,1: all forwarded, no strip
        repeat (5) drive(1'b1, 1'b1, 1'b0, K_DATA);
        drive(1'b1, 1'b0, 1'b0, K_DATA);
        drive(1'b1, 1'b1, 1'b0, K_DATA);
        idle(1);
        chk("t3_ones_cnt", int'(ones_cnt), 1);
        do_clear();

        // 4. Violation: seven 1s then 0,1; then clear and recover
        repeat (6) drive(1'b1, 1'b1, 1'b0, K_DATA);
        drive(1'b1, 1'b1, 1'b0, K_NONE);
        idle(1);
        chk("t4_err_set", int'(stuff_err), 1);
        drive(1'b1, 1'b0, 1'b0, K_NONE);
        drive(1'b1, 1'b1, 1'b0, K_NONE);
        idle(2);
        chk("t4_err_sticky", int'(stuff_err), 1);
        chk("t4_cnt_held", int'(ones_cnt), MAX_ONES);
        do_clear();
        chk("t4_err_cleared", int'(stuff_err), 0);
        chk("t4_cnt_cleared", int'(ones_cnt), 0);
        drive(1'b1, 1'b1, 1'b0, K_DATA);
        idle(1);
        chk("t4_recover_cnt", int'(ones_cnt), 1);
        do_clear();

        // 5. clear colliding with a bit in EXPECT0
        repeat (6) drive(1'b1, 1'b1, 1'b0, K_DATA);
        idle(1);
        chk("t5_cnt_full", int'(ones_cnt), MAX_ONES);
        drive(1'b1, 1'b1, 1'b1, K_NONE);
        idle(1);
        chk("t5_cnt_cleared", int'(ones_cnt), 0);
        chk("t5_no_err", int'(stuff_err), 0);
        drive(1'b1, 1'b1, 1'b0, K_DATA);
        idle(1);
        chk("t5_next_cnt", int'(ones_cnt), 1);
        do_clear();

        // 6. 0x7E LSB first with 3 idle cycles between strobes; final 0 is stripped
        dv_cnt = 0;
        strip_cnt = 0;
        drive(1'b1, 1'b0, 1'b0, K_DATA);
        idle(3);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, K_DATA);
            idle(3);
        end
        drive(1'b1, 1'b0, 1'b0, K_STRIP);
        idle(3);
        chk("t6_dv_pulses", dv_cnt, 7);
        chk("t6_strip_pulses", strip_cnt, 1);
        chk("t6_ones_cnt", int'(ones_cnt), 0);

        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
